vga_timing_gen: RTL

Parametrised VGA raster timing generator, successor to the fixed 640x480 generator in the stereo display path. Produces sync, blank and active-area strobes for any timing set given by parameters. Adds pixel-coordinate outputs, integer pixel-replication upscaling (1x/2x/4x), a side-by-side stereo split mode, and frame/line pulses. Frame-safe mode switching. Sits between the 25 MHz clock domain and the frame-buffer read/averaging logic and VGA DAC.

---
 rtl/vga_timing_gen.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel replication, side-by-side
// stereo split and frame-safe mode switching. All outputs are registered.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = 10
) (
  input  logic          CLK25,
  input  logic          RST,
  input  logic [1:0]    scale,
  input  logic          split,
  output logic          Hsync,
  output logic          Vsync,
  output logic          Nblank,
  output logic          Nsync,
  output logic          activeArea,
  output logic [CW-1:0] px_x,
  output logic [CW-1:0] px_y,
  output logic          side,
  output logic          new_pix,
  output logic          frame_start,
  output logic          line_start,
  output logic [1:0]    cur_scale
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] C_H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] C_H_HALF = CW'(H_ACTIVE / 2);
  localparam logic [CW-1:0] C_H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] C_HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] C_HS_END = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] C_V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] C_V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] C_VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] C_VS_END = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CW-1:0] r_hcnt;
  logic [CW-1:0] r_vcnt;
  logic [1:0]    r_scale_sh;
  logic          r_split_sh;

  logic          r_hs;
  logic          r_vs;
  logic          r_active;
  logic [CW-1:0] r_px_x;
  logic [CW-1:0] r_px_y;
  logic          r_side;
  logic          r_new_pix;
  logic          r_frame_start;
  logic          r_line_start;
  logic [1:0]    r_cur_scale;

  logic          w_h_wrap;
  logic          w_v_wrap;
  logic          w_active;
  logic          w_right;
  logic [CW-1:0] w_hx;
  logic [1:0]    w_shift;
  logic [CW-1:0] w_mask;
  logic          w_new_pix;
  logic          w_hs_on;
  logic          w_vs_on;

  assign w_h_wrap = (r_hcnt == C_H_LAST);
  assign w_v_wrap = (r_vcnt == C_V_LAST);

  // Mode shadows load on the last clock of the frame so the (0,0) pixel of the
  // next frame is already evaluated with the new mode.
  always_ff @(posedge CLK25 or posedge RST) begin
    if (RST) begin
      r_hcnt     <= '0;
      r_vcnt     <= '0;
      r_scale_sh <= '0;
      r_split_sh <= 1'b0;
    end else begin
      if (w_h_wrap) begin
        r_hcnt <= '0;
        if (w_v_wrap) begin
          r_vcnt <= '0;
        end else begin
          r_vcnt <= r_vcnt + 1'b1;
        end
      end else begin
        r_hcnt <= r_hcnt + 1'b1;
      end
      if (w_h_wrap && w_v_wrap) begin
        r_scale_sh <= scale;
        r_split_sh <= split;
      end
    end
  end

  // Scale code 11 falls back to 1x.
  always_comb begin
    w_shift = 2'd0;
    w_mask  = '0;
    case (r_scale_sh)
      2'b01: begin
        w_shift = 2'd1;
        w_mask  = CW'(1);
      end
      2'b10: begin
        w_shift = 2'd2;
        w_mask  = CW'(3);
      end
      default: begin
        w_shift = 2'd0;
        w_mask  = '0;
      end
    endcase
  end

  assign w_active  = (r_hcnt < C_H_ACT) && (r_vcnt < C_V_ACT);
  assign w_right   = r_split_sh && (r_hcnt >= C_H_HALF);
  assign w_hx      = w_right ? (r_hcnt - C_H_HALF) : r_hcnt;
  assign w_new_pix = w_active && ((w_hx & w_mask) == '0) && ((r_vcnt & w_mask) == '0);
  assign w_hs_on   = (r_hcnt >= C_HS_BEG) && (r_hcnt <= C_HS_END);
  assign w_vs_on   = (r_vcnt >= C_VS_BEG) && (r_vcnt <= C_VS_END);

  always_ff @(posedge CLK25 or posedge RST) begin
    if (RST) begin
      r_hs          <= ~HS_POL;
      r_vs          <= ~VS_POL;
      r_active      <= 1'b0;
      r_px_x        <= '0;
      r_px_y        <= '0;
      r_side        <= 1'b0;
      r_new_pix     <= 1'b0;
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
      r_cur_scale   <= '0;
    end else begin
      r_hs          <= w_hs_on ? HS_POL : ~HS_POL;
      r_vs          <= w_vs_on ? VS_POL : ~VS_POL;
      r_active      <= w_active;
      r_px_x        <= w_active ? (w_hx >> w_shift) : '0;
      r_px_y        <= w_active ? (r_vcnt >> w_shift) : '0;
      r_side        <= w_active && w_right;
      r_new_pix     <= w_new_pix;
      r_frame_start <= (r_hcnt == '0) && (r_vcnt == '0);
      r_line_start  <= (r_hcnt == '0) && (r_vcnt < C_V_ACT);
      r_cur_scale   <= r_scale_sh;
    end
  end

  assign Hsync       = r_hs;
  assign Vsync       = r_vs;
  assign Nblank      = r_active;
  assign activeArea  = r_active;
  assign Nsync       = 1'b1;
  assign px_x        = r_px_x;
  assign px_y        = r_px_y;
  assign side        = r_side;
  assign new_pix     = r_new_pix;
  assign frame_start = r_frame_start;
  assign line_start  = r_line_start;
  assign cur_scale   = r_cur_scale;

endmodule
